// File: rtl/frogger_pkg.sv
// ---------------------------------------------------------------------------
// frogger_pkg
// Shared types and playfield constants for the frogger game blocks.
// The sprite renderer and frog_ctrl both import this package so that they
// agree on the frog sprite size, the screen geometry and the facing codes.
//
// Contents:
//   facing_t  - 2-bit facing code (up, down, left, right)
//   state_t   - frog controller state (IDLE, HOP, DEAD)
//   SCREEN_W  - playfield width in pixels
//   SCREEN_H  - playfield height in pixels
//   FROG_SIZE - frog sprite edge in pixels
// ---------------------------------------------------------------------------
package frogger_pkg;

    typedef enum logic [1:0] {
        FACE_UP    = 2'b00,
        FACE_DOWN  = 2'b01,
        FACE_LEFT  = 2'b10,
        FACE_RIGHT = 2'b11
    } facing_t;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        DEAD
    } state_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FROG_SIZE = 32;

endpackage

// File: rtl/frog_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Frame-synchronous rising-edge detector for the four direction buttons,
// followed by a fixed-priority encoder (up > down > left > right).
//
// Ports:
//   clk         in   pixel clock
//   reset       in   asynchronous, active-high reset
//   frame_tick  in   one-cycle pulse per frame; buttons are sampled only here
//   btn[3:0]    in   button levels packed as {up, down, left, right}
//   press_valid out  high during a frame_tick that carries a new press
//   press_dir   out  facing code of the highest-priority new press
// ---------------------------------------------------------------------------
module btn_edge
    import frogger_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    output logic       press_valid,
    output logic [1:0] press_dir
);

    logic [3:0] prev;
    logic [3:0] rise;

    // The previous-sample register updates on every frame regardless of what
    // the controller is doing, so a button held through a hop or through the
    // death sequence never produces a late press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 4'b0000;
        end else if (frame_tick) begin
            prev <= btn;
        end
    end

    always_comb begin
        rise        = btn & ~prev;
        press_valid = frame_tick && (rise != 4'b0000);
        press_dir   = FACE_UP;
        if (rise[3]) begin
            press_dir = FACE_UP;
        end else if (rise[2]) begin
            press_dir = FACE_DOWN;
        end else if (rise[1]) begin
            press_dir = FACE_LEFT;
        end else if (rise[0]) begin
            press_dir = FACE_RIGHT;
        end
    end

endmodule

// File: rtl/frog_ctrl.sv
// ---------------------------------------------------------------------------
// frog_ctrl
// Frog position/facing controller. Button presses become animated grid hops,
// a kill pulse starts a timed death sequence followed by a respawn. Every
// visible change happens on frame_tick so the renderer never sees a
// half-updated frog.
//
// Ports:
//   clk         in   pixel clock
//   reset       in   asynchronous, active-high reset
//   frame_tick  in   one-cycle pulse at vblank start
//   btn_up/down/left/right in  synchronized button levels
//   kill        in   one-cycle collision pulse
//   frog_x      out  sprite left column
//   frog_y      out  sprite top row
//   frog_size   out  constant sprite edge (FROG_SIZE)
//   facing      out  00 up, 01 down, 10 left, 11 right
//   hopping     out  high while a hop is animating
//   dead        out  high during the death sequence
//   hop_done    out  one-cycle pulse after the final hop increment
// ---------------------------------------------------------------------------
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter int STEP        = 32,
    parameter int HOP_FRAMES  = 4,
    parameter int START_X     = 304,
    parameter int START_Y     = 448,
    parameter int DEAD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       kill,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [9:0] frog_size,
    output logic [1:0] facing,
    output logic       hopping,
    output logic       dead,
    output logic       hop_done
);

    localparam logic [9:0]        HOP_INC  = 10'(STEP / HOP_FRAMES);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - FROG_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - FROG_SIZE);
    localparam logic [9:0]        X_START  = 10'(START_X);
    localparam logic [9:0]        Y_START  = 10'(START_Y);
    // The entry tick already applies the first increment, so the HOP state
    // itself only sees HOP_FRAMES-1 ticks; the last one is at count HOP_FRAMES-2.
    localparam logic [7:0]        HOP_LAST  = 8'(HOP_FRAMES - 2);
    localparam logic [7:0]        DEAD_LAST = 8'(DEAD_FRAMES - 1);

    state_t      state;
    state_t      state_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [9:0]  x_n;
    logic [9:0]  y_n;
    logic [1:0]  facing_n;
    logic        hop_done_n;

    logic        press_valid;
    logic [1:0]  press_dir;
    logic [1:0]  move_dir;
    logic [9:0]  moved_x;
    logic [9:0]  moved_y;
    logic signed [10:0] target_x;
    logic signed [10:0] target_y;
    logic        in_bounds;

    btn_edge u_btn_edge (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn         ({btn_up, btn_down, btn_left, btn_right}),
        .press_valid (press_valid),
        .press_dir   (press_dir)
    );

    assign frog_size = 10'(FROG_SIZE);
    assign hopping   = (state == HOP);
    assign dead      = (state == DEAD);

    // Movement datapath. In IDLE the direction comes from the new press (the
    // hop's first increment and its bounds check); in HOP it follows the
    // latched facing. Targets are 11-bit signed so a hop off the top/left
    // edge shows up as negative instead of wrapping to a large position.
    always_comb begin
        move_dir = (state == IDLE) ? press_dir : facing;
        moved_x  = frog_x;
        moved_y  = frog_y;
        target_x = $signed({1'b0, frog_x});
        target_y = $signed({1'b0, frog_y});
        case (move_dir)
            FACE_UP: begin
                moved_y  = frog_y - HOP_INC;
                target_y = $signed({1'b0, frog_y}) - STEP_S;
            end
            FACE_DOWN: begin
                moved_y  = frog_y + HOP_INC;
                target_y = $signed({1'b0, frog_y}) + STEP_S;
            end
            FACE_LEFT: begin
                moved_x  = frog_x - HOP_INC;
                target_x = $signed({1'b0, frog_x}) - STEP_S;
            end
            FACE_RIGHT: begin
                moved_x  = frog_x + HOP_INC;
                target_x = $signed({1'b0, frog_x}) + STEP_S;
            end
        endcase
        in_bounds = !target_x[10] && (target_x <= X_MAX) &&
                    !target_y[10] && (target_y <= Y_MAX);
    end

    // State and visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            frog_x   <= X_START;
            frog_y   <= Y_START;
            facing   <= FACE_UP;
            hop_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            frog_x   <= x_n;
            frog_y   <= y_n;
            facing   <= facing_n;
            hop_done <= hop_done_n;
        end
    end

    // Next-state logic. Kill is checked before frame_tick in IDLE and HOP so
    // a coincident kill freezes the frog where it is. A press that would
    // leave the playfield still turns the frog but does not start a hop.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        x_n        = frog_x;
        y_n        = frog_y;
        facing_n   = facing;
        hop_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (kill) begin
                    state_n = DEAD;
                    cnt_n   = 8'd0;
                end else if (press_valid) begin
                    facing_n = press_dir;
                    if (in_bounds) begin
                        state_n = HOP;
                        cnt_n   = 8'd0;
                        x_n     = moved_x;
                        y_n     = moved_y;
                    end
                end
            end
            HOP: begin
                if (kill) begin
                    state_n = DEAD;
                    cnt_n   = 8'd0;
                end else if (frame_tick) begin
                    x_n = moved_x;
                    y_n = moved_y;
                    if (cnt == HOP_LAST) begin
                        state_n    = IDLE;
                        hop_done_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            DEAD: begin
                if (frame_tick) begin
                    if (cnt == DEAD_LAST) begin
                        state_n  = IDLE;
                        x_n      = X_START;
                        y_n      = Y_START;
                        facing_n = FACE_UP;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frog_ctrl
// Table-driven bench for frog_ctrl. Each record is one frame: button levels,
// whether a frame_tick and/or kill is pulsed, and the outputs expected right
// after that pulse. Hand-written sequences cover async reset mid-hop and in
// the death sequence.
// ---------------------------------------------------------------------------
module tb_frog_ctrl;

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        logic       tick;
        logic       kill;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] f;
        logic       h;
        logic       d;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       kill = 1'b0;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [9:0] frog_size;
    logic [1:0] facing;
    logic       hopping;
    logic       dead;
    logic       hop_done;

    vec_t vecs[$];
    int   vec_count = 0;
    int   err_count = 0;
    int   mx;
    int   my;

    frog_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .kill       (kill),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .frog_size  (frog_size),
        .facing     (facing),
        .hopping    (hopping),
        .dead       (dead),
        .hop_done   (hop_done)
    );

    always #5 clk = ~clk;

    function automatic void addVec(input logic [3:0] btn, input logic tick,
                                   input logic kl, input int x, input int y,
                                   input logic [1:0] f, input logic h,
                                   input logic d, input logic done);
        vec_t v;
        v.btn  = btn;
        v.tick = tick;
        v.kill = kl;
        v.x    = 10'(x);
        v.y    = 10'(y);
        v.f    = f;
        v.h    = h;
        v.d    = d;
        v.done = done;
        vecs.push_back(v);
    endfunction

    // One full hop from the model position (mx, my): press frame plus three
    // follow-up frames with the button released, 8 pixels per frame.
    function automatic void addHop(input logic [3:0] btn, input int dx,
                                   input int dy, input logic [1:0] f);
        for (int i = 0; i < 4; i++) begin
            mx = mx + dx;
            my = my + dy;
            addVec((i == 0) ? btn : 4'b0000, 1'b1, 1'b0, mx, my, f,
                   (i != 3), 1'b0, (i == 3));
        end
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] ex,
                               input logic [9:0] ey, input logic [1:0] ef,
                               input logic eh, input logic ed,
                               input logic edone);
        vec_count++;
        if (frog_x !== ex || frog_y !== ey || facing !== ef ||
            hopping !== eh || dead !== ed || hop_done !== edone) begin
            err_count++;
            $display("[TB] FAIL %s: got x=%0d y=%0d f=%0d hop=%0b dead=%0b done=%0b, expected x=%0d y=%0d f=%0d hop=%0b dead=%0b done=%0b",
                     name, frog_x, frog_y, facing, hopping, dead, hop_done,
                     ex, ey, ef, eh, ed, edone);
        end
    endtask

    // Drive one frame's pulse at a negedge, release it one cycle later and
    // check right after the edge that consumed it.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = v.btn;
        frame_tick = v.tick;
        kill       = v.kill;
        @(negedge clk);
        frame_tick = 1'b0;
        kill       = 1'b0;
        checkOutput(name, v.x, v.y, v.f, v.h, v.d, v.done);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t v;

        // Idle frames at the start position.
        for (int i = 0; i < 10; i++) addVec(4'b0000, 1, 0, 304, 448, 2'b00, 0, 0, 0);
        // Down at the bottom row is blocked: turn only.
        addVec(4'b0100, 1, 0, 304, 448, 2'b01, 0, 0, 0);
        addVec(4'b0000, 1, 0, 304, 448, 2'b01, 0, 0, 0);
        // Up hop.
        addVec(4'b1000, 1, 0, 304, 440, 2'b00, 1, 0, 0);
        addVec(4'b0000, 1, 0, 304, 432, 2'b00, 1, 0, 0);
        addVec(4'b0000, 1, 0, 304, 424, 2'b00, 1, 0, 0);
        addVec(4'b0000, 1, 0, 304, 416, 2'b00, 0, 0, 1);
        addVec(4'b0000, 1, 0, 304, 416, 2'b00, 0, 0, 0);
        // Left+right together: left wins; left held through and after the hop.
        addVec(4'b0011, 1, 0, 296, 416, 2'b10, 1, 0, 0);
        addVec(4'b0010, 1, 0, 288, 416, 2'b10, 1, 0, 0);
        addVec(4'b0010, 1, 0, 280, 416, 2'b10, 1, 0, 0);
        addVec(4'b0010, 1, 0, 272, 416, 2'b10, 0, 0, 1);
        for (int i = 0; i < 8; i++) addVec(4'b0010, 1, 0, 272, 416, 2'b10, 0, 0, 0);
        addVec(4'b0000, 1, 0, 272, 416, 2'b10, 0, 0, 0);
        // Re-press left after release hops again.
        addVec(4'b0010, 1, 0, 264, 416, 2'b10, 1, 0, 0);
        addVec(4'b0000, 1, 0, 256, 416, 2'b10, 1, 0, 0);
        addVec(4'b0000, 1, 0, 248, 416, 2'b10, 1, 0, 0);
        addVec(4'b0000, 1, 0, 240, 416, 2'b10, 0, 0, 1);
        // Kill (no tick) after two hop frames: frozen, no hop_done.
        addVec(4'b0010, 1, 0, 232, 416, 2'b10, 1, 0, 0);
        addVec(4'b0000, 1, 0, 224, 416, 2'b10, 1, 0, 0);
        addVec(4'b0000, 0, 1, 224, 416, 2'b10, 0, 1, 0);
        // 29 dead frames; press up on frame 5 and kill again on frame 10,
        // both ignored. Respawn on frame 30.
        for (int k = 1; k < 30; k++)
            addVec((k == 5) ? 4'b1000 : 4'b0000, 1, (k == 10), 224, 416, 2'b10, 0, 1, 0);
        addVec(4'b0000, 1, 0, 304, 448, 2'b00, 0, 0, 0);
        // Kill coinciding with a hop tick: no movement applied.
        addVec(4'b1000, 1, 0, 304, 440, 2'b00, 1, 0, 0);
        addVec(4'b0000, 1, 1, 304, 440, 2'b00, 0, 1, 0);
        for (int k = 1; k < 30; k++) addVec(4'b0000, 1, 0, 304, 440, 2'b00, 0, 1, 0);
        addVec(4'b0000, 1, 0, 304, 448, 2'b00, 0, 0, 0);
        // Nine hops left to x=16; the next left would go negative.
        mx = 304;
        my = 448;
        for (int i = 0; i < 9; i++) addHop(4'b0010, -8, 0, 2'b10);
        addVec(4'b0010, 1, 0, 16, 448, 2'b10, 0, 0, 0);
        addVec(4'b0000, 1, 0, 16, 448, 2'b10, 0, 0, 0);
        // Fourteen hops up to y=0; the next up is blocked.
        for (int i = 0; i < 14; i++) addHop(4'b1000, 0, -8, 2'b00);
        addVec(4'b1000, 1, 0, 16, 0, 2'b00, 0, 0, 0);
        addVec(4'b0000, 1, 0, 16, 0, 2'b00, 0, 0, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("in_reset", 10'd304, 10'd448, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset", 10'd304, 10'd448, 2'b00, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (frog_size !== 10'd32) begin
            err_count++;
            $display("[TB] FAIL frog_size: got %0d, expected 32", frog_size);
        end

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Async reset mid-hop (right hop from x=16).
        v = '{btn: 4'b0001, tick: 1'b1, kill: 1'b0, x: 10'd24, y: 10'd0,
              f: 2'b11, h: 1'b1, d: 1'b0, done: 1'b0};
        applyStimulus(v, "right_press");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("reset_mid_hop", 10'd304, 10'd448, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        btn_right = 1'b0;
        reset = 1'b0;

        // Async reset while dead.
        v = '{btn: 4'b0000, tick: 1'b0, kill: 1'b1, x: 10'd304, y: 10'd448,
              f: 2'b00, h: 1'b0, d: 1'b1, done: 1'b0};
        applyStimulus(v, "kill_idle");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("reset_in_dead", 10'd304, 10'd448, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
